// File: rtl/spi_ram_slave_if.sv
// Serial link between an SPI-style master and spi_ram_slave: frame select, command/payload in,
// read data out.
interface spi_ram_slave_if;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport master (
    output SS_n,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/spi_ram_slave.sv
// Serial RAM slave: each frame is a 2-bit opcode (write addr, write data, read addr, read data)
// followed by its payload. Define SPI_RAM_AUTOINC_EN for burst data frames with address increment.
module spi_ram_slave #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input logic            clk,
  input logic            rst_n,
  spi_ram_slave_if.slave spi
);

  localparam int unsigned SHIFT_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_WIDTH   = $clog2(SHIFT_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StRdData
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]  rd_sel;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic                   wr_pend_q, wr_pend_d;
  logic                   miso_q, miso_d;
  logic                   armed_q, armed_d;
  logic                   mem_we;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < MEM_DEPTH;
  endfunction

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) == MEM_DEPTH - 1) ? '0 : a + 1'b1;
  endfunction

  // While streaming, the only fetch is the prefetch of the following word.
  assign rd_sel = (state_q == StRdData) ? addr_inc(rd_addr_q) : rd_addr_q;
`else
  assign rd_sel = rd_addr_q;
`endif

  assign rd_word  = in_range(rd_sel) ? mem[rd_sel] : '0;
  assign shift_in = {shift_q[SHIFT_WIDTH-2:0], spi.MOSI};
  assign spi.MISO = miso_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    wr_pend_d = 1'b0;
    miso_d    = 1'b0;
    armed_d   = armed_q | spi.SS_n;
    mem_we    = 1'b0;

    // A fully received word commits one edge later even if the frame has just closed.
    if (wr_pend_q) begin
      mem_we = in_range(wr_addr_q);
`ifdef SPI_RAM_AUTOINC_EN
      wr_addr_d = addr_inc(wr_addr_q);
`endif
    end

    if (spi.SS_n) begin
      state_d = StIdle;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (armed_q) begin
            state_d = StCmd;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        StCmd: begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) begin
            cnt_d   = '0;
            shift_d = '0;
            unique case (shift_in[1:0])
              2'b00: state_d = StWrAddr;
              2'b01: state_d = StWrData;
              2'b10: state_d = StRdAddr;
              2'b11: state_d = StRdWait;
            endcase
          end
        end
        StWrAddr, StRdAddr: begin
          // Counter parks at ADDR_WIDTH so trailing bits are ignored.
          if (cnt_q < CNT_WIDTH'(ADDR_WIDTH)) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_WIDTH'(ADDR_WIDTH - 1)) begin
              if (state_q == StWrAddr) begin
                wr_addr_d = shift_in[ADDR_WIDTH-1:0];
              end else begin
                rd_addr_d = shift_in[ADDR_WIDTH-1:0];
              end
            end
          end
        end
        StWrData: begin
          if (cnt_q < CNT_WIDTH'(DATA_WIDTH)) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
              wr_data_d = shift_in[DATA_WIDTH-1:0];
              wr_pend_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
              cnt_d   = '0;
              shift_d = '0;
`endif
            end
          end
        end
        StRdWait: begin
          shift_d = SHIFT_WIDTH'(rd_word);
          cnt_d   = '0;
          state_d = StRdData;
        end
        StRdData: begin
          if (cnt_q < CNT_WIDTH'(DATA_WIDTH)) begin
            miso_d  = shift_q[DATA_WIDTH-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            // Load the next word while the LSB goes out so its MSB follows with no gap.
            if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
              shift_d   = SHIFT_WIDTH'(rd_word);
              rd_addr_d = rd_sel;
              cnt_d     = '0;
            end
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      wr_pend_q <= 1'b0;
      miso_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      wr_pend_q <= wr_pend_d;
      miso_q    <= miso_d;
      armed_q   <= armed_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

endmodule

// File: tb/tb_spi_ram_slave.sv
// Randomized bench for spi_ram_slave against a word-level RAM/address model.
module tb_spi_ram_slave;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;

  spi_ram_slave_if bus ();

  spi_ram_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .spi  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: RAM contents and the two address pointers.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_wr;
  logic [7:0] m_rd;

  logic       tx_q [$];
  logic       rx_rec [128];
  logic [7:0] wd [4];
  logic [7:0] rd_got [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_inc(input logic [7:0] a);
    return (a == 8'(DEPTH - 1)) ? 8'h00 : a + 8'h01;
  endfunction

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
  endtask

  // One frame of `total` edges after the select edge; queued bits first, then random filler.
  task automatic run_frame(input int total);
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    @(negedge clk);
    for (int j = 1; j <= total; j++) begin
      if (tx_q.size() > 0) bus.MOSI = tx_q.pop_front();
      else bus.MOSI = 1'($urandom);
      @(negedge clk);
      rx_rec[j] = bus.MISO;
    end
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(negedge clk);
    check_eq("miso_idle", 32'(bus.MISO), 32'h0);
  endtask

  task automatic do_write_addr(input logic [7:0] a);
    push_bits(32'h0, 2);
    push_bits(32'(a), AW);
    run_frame(AW + 2 + int'($urandom_range(0, 3)));
    m_wr = a;
  endtask

  task automatic do_read_addr(input logic [7:0] a);
    push_bits(32'h2, 2);
    push_bits(32'(a), AW);
    run_frame(AW + 2 + int'($urandom_range(0, 3)));
    m_rd = a;
  endtask

  task automatic do_write_data(input int n);
    push_bits(32'h1, 2);
    for (int w = 0; w < n; w++) push_bits(32'(wd[w]), DW);
    run_frame(3 + n * DW + int'($urandom_range(0, 2)));
    for (int w = 0; w < n; w++) begin
`ifdef SPI_RAM_AUTOINC_EN
      m_mem[m_wr] = wd[w];
      m_wr = m_inc(m_wr);
`else
      if (w == 0) m_mem[m_wr] = wd[w];
`endif
    end
  endtask

  task automatic do_read(input int n, input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    logic [7:0] a;
    push_bits(32'h3, 2);
    run_frame(3 + n * DW + 2);
    check_eq({tag, "_lead"}, 32'({rx_rec[1], rx_rec[2], rx_rec[3]}), 32'h0);
    a = m_rd;
    for (int w = 0; w < n; w++) begin
      got = '0;
      for (int b = 0; b < DW; b++) got = {got[6:0], rx_rec[4 + w * DW + b]};
`ifdef SPI_RAM_AUTOINC_EN
      exp = m_mem[a];
      a   = m_inc(a);
`else
      exp = (w == 0) ? m_mem[a] : 8'h00;
`endif
      check_eq(tag, 32'(got), 32'(exp));
      rd_got[w] = got;
    end
`ifdef SPI_RAM_AUTOINC_EN
    m_rd = a;
`else
    check_eq({tag, "_tail"}, 32'({rx_rec[4 + n * DW], rx_rec[5 + n * DW]}), 32'h0);
`endif
  endtask

  initial begin
    logic bad;
    logic [10:0] pat;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_miso", 32'(bus.MISO), 32'h0);
    rst_n = 1'b1;
    m_wr  = 8'h00;
    m_rd  = 8'h00;
    repeat (2) @(negedge clk);

    // Both pointers start at 0 out of reset.
    wd[0] = 8'h5A;
    do_write_data(1);
    do_read(1, "rd_default_addr");
    check_eq("rd_default_lit", 32'(rd_got[0]), 32'h5A);

    do_write_addr(8'hF1);
    wd[0] = 8'h77;
    do_write_data(1);
    do_read_addr(8'hF1);
    do_read(1, "basic_rw");
    check_eq("basic_rw_lit", 32'(rd_got[0]), 32'h77);

    // Write-data frame cut after 4 payload bits.
    do_write_addr(8'hF1);
    push_bits(32'h1, 2);
    push_bits(32'hA, 4);
    run_frame(6);
    do_read_addr(8'hF1);
    do_read(1, "abort_ram");
    check_eq("abort_ram_lit", 32'(rd_got[0]), 32'h77);
    wd[0] = 8'h99;
    do_write_data(1);
    do_read_addr(8'hF1);
    do_read(1, "abort_wr_addr");
    check_eq("abort_wr_addr_lit", 32'(rd_got[0]), 32'h99);
    do_write_addr(8'hF1);
    wd[0] = 8'h77;
    do_write_data(1);

`ifdef SPI_RAM_AUTOINC_EN
    do_write_addr(8'h10);
    wd[0] = 8'hA1; wd[1] = 8'hB2; wd[2] = 8'hC3;
    do_write_data(3);
    do_read_addr(8'h10);
    do_read(3, "burst");
    check_eq("burst_lit", 32'({rd_got[0], rd_got[1], rd_got[2]}), 32'hA1B2C3);
    do_write_addr(8'hFF);
    wd[0] = 8'h11; wd[1] = 8'h22;
    do_write_data(2);
    do_read_addr(8'hFF);
    do_read(2, "wrap");
    check_eq("wrap_lit", 32'({rd_got[0], rd_got[1]}), 32'h1122);
    wd[0] = 8'h33;
    do_write_data(1);
    do_read_addr(8'h01);
    do_read(1, "wrap_wr_addr");
    check_eq("wrap_wr_addr_lit", 32'(rd_got[0]), 32'h33);
`else
    do_write_addr(8'h21);
    wd[0] = 8'h5C;
    do_write_data(1);
    do_write_addr(8'h20);
    wd[0] = 8'hA1; wd[1] = 8'hB2;
    do_write_data(2);
    do_read_addr(8'h20);
    do_read(1, "single_word_a");
    check_eq("single_word_a_lit", 32'(rd_got[0]), 32'hA1);
    do_read_addr(8'h21);
    do_read(1, "single_word_b");
    check_eq("single_word_b_lit", 32'(rd_got[0]), 32'h5C);
`endif

    // Reset asserted while read data is streaming.
    do_read_addr(8'hF1);
    @(negedge clk);
    bus.SS_n = 1'b0;
    @(negedge clk);
    bus.MOSI = 1'b1; @(negedge clk);
    bus.MOSI = 1'b1; @(negedge clk);
    repeat (5) begin
      bus.MOSI = 1'($urandom);
      @(negedge clk);
    end
    check_eq("rst_pre_miso", 32'(bus.MISO), 32'(m_mem[8'hF1][4]));
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async_miso", 32'(bus.MISO), 32'h0);
    m_wr = 8'h00;
    m_rd = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // SS_n never rose after reset: this read-address pattern must be ignored.
    pat = {1'b0, 2'b10, 8'h33};
    bad = 1'b0;
    for (int j = 10; j >= 0; j--) begin
      bus.MOSI = pat[j];
      @(negedge clk);
      bad = bad | bus.MISO;
    end
    check_eq("unarmed_miso", 32'(bad), 32'h0);
    bus.SS_n = 1'b1;
    @(negedge clk);
    do_read(1, "post_rst_rd_addr");
    wd[0] = 8'h3C;
    do_write_data(1);
    do_read_addr(8'h00);
    do_read(1, "post_rst_wr_addr");
    check_eq("post_rst_wr_addr_lit", 32'(rd_got[0]), 32'h3C);
    do_read_addr(8'hF1);
    do_read(1, "ram_kept");
    check_eq("ram_kept_lit", 32'(rd_got[0]), 32'h77);

    for (int a = 8'h30; a <= 8'h3F; a++) begin
      do_write_addr(8'(a));
      wd[0] = 8'($urandom) | 8'h80;
      do_write_data(1);
    end

    for (int it = 0; it < 40; it++) begin
      int n;
      logic [7:0] a;
      n = int'($urandom_range(1, 3));
      a = 8'(8'h30 + $urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) begin
        do_write_addr(a);
        for (int w = 0; w < n; w++) wd[w] = 8'($urandom);
        do_write_data(n);
      end else begin
        do_read_addr(a);
        do_read(n, "rand_rd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
